// File: rtl/space_invaders_pkg.sv
// Shared definitions for the space-invaders pixel pipeline.
//   laser_state_e : one-hot player-laser FSM encoding (IDLE/FLYING/COOLDOWN)
//   SCREEN_*      : playfield borders in pixels
//   color_t       : 12-bit {R,G,B} colour, 4 bits per channel
//   is_onehot3    : true when a 3-bit state vector is one of the legal encodings
package space_invaders_pkg;

   typedef enum logic [2:0] {
      LASER_IDLE     = 3'b001,
      LASER_FLYING   = 3'b010,
      LASER_COOLDOWN = 3'b100
   } laser_state_e;

   localparam logic [9:0] SCREEN_LEFT  = 10'd9;
   localparam logic [9:0] SCREEN_RIGHT = 10'd630;
   localparam logic [9:0] SCREEN_TOP   = 10'd8;

   typedef logic [11:0] color_t;

   function automatic logic is_onehot3(input logic [2:0] s);
      return (s == 3'b001) || (s == 3'b010) || (s == 3'b100);
   endfunction

endpackage

// File: rtl/player_laser_if.sv
// Bundle between the player laser and its neighbours.
//   Inputs to the laser : tick_i, fire_i, enable_i, gun_pos_i, hit_enemy_i
//   Outputs of the laser: active_o, shot_laser_o, kill_o, x_o, y_top_o, y_bot_o,
//                         laser_red_o/green_o/blue_o, state_o
//   modport slave  : the laser itself
//   modport master : whatever drives the laser (player FSM, collision logic)
interface player_laser_if;

   logic       tick_i;
   logic       fire_i;
   logic       enable_i;
   logic [9:0] gun_pos_i;
   logic       hit_enemy_i;

   logic       active_o;
   logic       shot_laser_o;
   logic       kill_o;
   logic [9:0] x_o;
   logic [9:0] y_top_o;
   logic [9:0] y_bot_o;
   logic [3:0] laser_red_o;
   logic [3:0] laser_green_o;
   logic [3:0] laser_blue_o;
   logic [2:0] state_o;

   modport slave (
      input  tick_i, fire_i, enable_i, gun_pos_i, hit_enemy_i,
      output active_o, shot_laser_o, kill_o, x_o, y_top_o, y_bot_o,
             laser_red_o, laser_green_o, laser_blue_o, state_o
   );

   modport master (
      output tick_i, fire_i, enable_i, gun_pos_i, hit_enemy_i,
      input  active_o, shot_laser_o, kill_o, x_o, y_top_o, y_bot_o,
             laser_red_o, laser_green_o, laser_blue_o, state_o
   );

endinterface

// File: rtl/player_laser_counter.sv
// Small loadable down-counter that saturates at zero.
//   clk_i, reset_i : clock and synchronous active-high reset
//   clr_i          : force count to zero (highest priority after reset)
//   load_i         : load load_val_i
//   down_i         : decrement by one (ignored at zero)
//   zero_o         : count is zero
module player_laser_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             down_i,
   output logic             zero_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (load_i) begin
         count_d = load_val_i;
      end else if (down_i && (count_q != '0)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/player_laser.sv
// Player's single laser shot.
// Spawns one bullet at the gun position on a fire-button rising edge, moves it
// up by step_p pixels on every frame tick, and retires it on an enemy hit or
// when it reaches the top border. After retirement a cooldown of cooldown_p
// ticks must elapse before the next shot.
//   clk_i, reset_i : clock and synchronous active-high reset
//   laser_if       : slave side of player_laser_if (inputs from the player FSM
//                    and collision logic, laser position/colour/status out)
module player_laser
   import space_invaders_pkg::*;
#(
   parameter color_t     color_p      = 12'hFFF,
   parameter logic [9:0] step_p       = 10'd4,
   parameter logic [9:0] spawn_y_p    = 10'd440,
   parameter logic [9:0] top_border_p = SCREEN_TOP,
   parameter logic [9:0] length_p     = 10'd12,
   parameter logic [7:0] cooldown_p   = 8'd15
) (
   input  logic           clk_i,
   input  logic           reset_i,
   player_laser_if.slave  laser_if
);

   laser_state_e state_q, state_d;
   logic [9:0]   x_q, x_d;
   logic [9:0]   y_q, y_d;
   logic         shot_q, shot_d;
   logic         kill_q, kill_d;
   logic         fire_q;
   logic         fire_rise;

   logic         cnt_clr;
   logic         cnt_load;
   logic         cnt_down;
   logic         cnt_zero;

   // Edge detect so a held button fires only once; edges seen outside IDLE
   // are simply lost.
   assign fire_rise = laser_if.fire_i & ~fire_q;

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      shot_d   = 1'b0;
      kill_d   = 1'b0;
      cnt_clr  = 1'b0;
      cnt_load = 1'b0;
      cnt_down = 1'b0;

      case (state_q)
         LASER_IDLE: begin
            if (laser_if.enable_i && fire_rise) begin
               state_d = LASER_FLYING;
               x_d     = laser_if.gun_pos_i;
               y_d     = spawn_y_p;
               shot_d  = 1'b1;
            end
         end

         LASER_FLYING: begin
            if (!laser_if.enable_i) begin
               // Player hit or paused: laser vanishes, no cooldown.
               state_d = LASER_IDLE;
            end else if (laser_if.hit_enemy_i) begin
               // Hit beats a same-cycle tick, so position freezes at impact.
               state_d  = LASER_COOLDOWN;
               kill_d   = 1'b1;
               cnt_load = 1'b1;
            end else if (laser_if.tick_i && (y_q < top_border_p + step_p)) begin
               state_d  = LASER_COOLDOWN;
               cnt_load = 1'b1;
            end else if (laser_if.tick_i) begin
               y_d = y_q - step_p;
            end
         end

         LASER_COOLDOWN: begin
            if (!laser_if.enable_i) begin
               state_d = LASER_IDLE;
               cnt_clr = 1'b1;
            end else if (laser_if.tick_i) begin
               if (cnt_zero) begin
                  state_d = LASER_IDLE;
               end else begin
                  cnt_down = 1'b1;
               end
            end
         end

         default: begin
            // Corrupted encoding: recover to a clean IDLE.
            state_d = LASER_IDLE;
            cnt_clr = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= LASER_IDLE;
         x_q     <= '0;
         y_q     <= spawn_y_p;
         shot_q  <= 1'b0;
         kill_q  <= 1'b0;
         fire_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         shot_q  <= shot_d;
         kill_q  <= kill_d;
         fire_q  <= laser_if.fire_i;
      end
   end

   player_laser_counter #(
      .WIDTH (8)
   ) u_cooldown (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .clr_i      (cnt_clr),
      .load_i     (cnt_load),
      .load_val_i (cooldown_p),
      .down_i     (cnt_down),
      .zero_o     (cnt_zero)
   );

   assign laser_if.active_o      = (state_q == LASER_FLYING);
   assign laser_if.shot_laser_o  = shot_q;
   assign laser_if.kill_o        = kill_q;
   assign laser_if.x_o           = x_q;
   assign laser_if.y_top_o       = y_q;
   assign laser_if.y_bot_o       = y_q + length_p - 10'd1;
   assign laser_if.laser_red_o   = color_p[11:8];
   assign laser_if.laser_green_o = color_p[7:4];
   assign laser_if.laser_blue_o  = color_p[3:0];
   assign laser_if.state_o       = state_q;

   a_state_onehot : assert property (@(posedge clk_i) disable iff (reset_i) is_onehot3(state_q))
      else $error("player_laser: illegal state encoding %b", state_q);

endmodule

// File: tb/tb_player_laser.sv
// Directed bench for player_laser: fire latency, held-button single shot,
// flight to the top border, cooldown timing, hit/tick collision, enable drop,
// reset in flight/cooldown and recovery from an illegal state encoding.
module tb_player_laser;
   import space_invaders_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   player_laser_if lif();

   player_laser dut (
      .clk_i    (clk),
      .reset_i  (rst),
      .laser_if (lif.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         lif.tick_i = 1'b1;
         step();
         lif.tick_i = 1'b0;
      end
   endtask

   task automatic fire_edge();
      lif.fire_i = 1'b0;
      step();
      lif.fire_i = 1'b1;
      step();
   endtask

   task automatic test_reset();
      lif.tick_i = 0; lif.fire_i = 0; lif.enable_i = 0; lif.gun_pos_i = 0; lif.hit_enemy_i = 0;
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      checks++; if (lif.state_o !== 3'b001) begin errors++; $display("FAIL reset_state: got %b want 001", lif.state_o); end
      checks++; if (lif.active_o !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", lif.active_o); end
      checks++; if (lif.x_o !== 10'd0) begin errors++; $display("FAIL reset_x: got %0d want 0", lif.x_o); end
      checks++; if (lif.y_top_o !== 10'd440) begin errors++; $display("FAIL reset_y: got %0d want 440", lif.y_top_o); end
      checks++; if (lif.shot_laser_o !== 1'b0 || lif.kill_o !== 1'b0) begin errors++; $display("FAIL reset_pulses: got shot=%b kill=%b want 0 0", lif.shot_laser_o, lif.kill_o); end
      checks++; if ({lif.laser_red_o, lif.laser_green_o, lif.laser_blue_o} !== 12'hFFF) begin errors++; $display("FAIL colour: got %h want fff", {lif.laser_red_o, lif.laser_green_o, lif.laser_blue_o}); end
      $display("reset done: state=%b y_top=%0d", lif.state_o, lif.y_top_o);
   endtask

   task automatic test_fire_latency();
      lif.enable_i = 1'b1; lif.gun_pos_i = 10'd300; lif.fire_i = 1'b1;
      step();
      checks++; if (lif.active_o !== 1'b1) begin errors++; $display("FAIL fire_active: got %b want 1", lif.active_o); end
      checks++; if (lif.shot_laser_o !== 1'b1) begin errors++; $display("FAIL fire_shot: got %b want 1", lif.shot_laser_o); end
      checks++; if (lif.x_o !== 10'd300) begin errors++; $display("FAIL fire_x: got %0d want 300", lif.x_o); end
      checks++; if (lif.y_top_o !== 10'd440 || lif.y_bot_o !== 10'd451) begin errors++; $display("FAIL fire_y: got top=%0d bot=%0d want 440 451", lif.y_top_o, lif.y_bot_o); end
      checks++; if (lif.state_o !== 3'b010) begin errors++; $display("FAIL fire_state: got %b want 010", lif.state_o); end
      lif.gun_pos_i = 10'd123; lif.fire_i = 1'b0;
      step();
      checks++; if (lif.shot_laser_o !== 1'b0) begin errors++; $display("FAIL shot_width: got %b want 0", lif.shot_laser_o); end
      checks++; if (lif.x_o !== 10'd300) begin errors++; $display("FAIL x_hold: got %0d want 300", lif.x_o); end
      $display("fire: x=%0d y_top=%0d y_bot=%0d", lif.x_o, lif.y_top_o, lif.y_bot_o);
   endtask

   task automatic test_hold_fire();
      int shots = 0;
      lif.enable_i = 1'b0;
      step();
      checks++; if (lif.state_o !== 3'b001) begin errors++; $display("FAIL abort_state: got %b want 001", lif.state_o); end
      lif.enable_i = 1'b1; lif.gun_pos_i = SCREEN_LEFT; lif.fire_i = 1'b1;
      for (int i = 0; i < 200; i++) begin
         lif.tick_i = ((i % 20) == 10);
         step();
         if (lif.shot_laser_o === 1'b1) shots++;
      end
      lif.tick_i = 1'b0;
      checks++; if (shots !== 1) begin errors++; $display("FAIL hold_shots: got %0d want 1", shots); end
      checks++; if (lif.y_top_o !== 10'd400) begin errors++; $display("FAIL hold_y: got %0d want 400", lif.y_top_o); end
      checks++; if (lif.x_o !== SCREEN_LEFT) begin errors++; $display("FAIL hold_x: got %0d want %0d", lif.x_o, SCREEN_LEFT); end
      $display("hold fire: shots=%0d y_top=%0d", shots, lif.y_top_o);
   endtask

   task automatic test_fly_to_top();
      lif.enable_i = 1'b0;
      step();
      lif.enable_i = 1'b1; lif.gun_pos_i = SCREEN_RIGHT;
      fire_edge();
      tick_n(108);
      checks++; if (lif.y_top_o !== 10'd8 || lif.state_o !== 3'b010) begin errors++; $display("FAIL top_y: got y=%0d state=%b want 8 010", lif.y_top_o, lif.state_o); end
      tick_n(1);
      checks++; if (lif.state_o !== 3'b100 || lif.active_o !== 1'b0) begin errors++; $display("FAIL top_retire: got state=%b active=%b want 100 0", lif.state_o, lif.active_o); end
      checks++; if (lif.kill_o !== 1'b0 || lif.y_top_o !== 10'd8) begin errors++; $display("FAIL top_nokill: got kill=%b y=%0d want 0 8", lif.kill_o, lif.y_top_o); end
      tick_n(15);
      fire_edge();
      checks++; if (lif.state_o !== 3'b100 || lif.shot_laser_o !== 1'b0) begin errors++; $display("FAIL cooldown_ignore: got state=%b shot=%b want 100 0", lif.state_o, lif.shot_laser_o); end
      lif.fire_i = 1'b0;
      tick_n(1);
      checks++; if (lif.state_o !== 3'b001) begin errors++; $display("FAIL cooldown_end: got %b want 001", lif.state_o); end
      lif.fire_i = 1'b1;
      step();
      checks++; if (lif.active_o !== 1'b1 || lif.shot_laser_o !== 1'b1) begin errors++; $display("FAIL refire: got active=%b shot=%b want 1 1", lif.active_o, lif.shot_laser_o); end
      $display("fly to top: refire state=%b y_top=%0d", lif.state_o, lif.y_top_o);
   endtask

   task automatic test_hit_with_tick();
      tick_n(60);
      checks++; if (lif.y_top_o !== 10'd200) begin errors++; $display("FAIL hit_pre_y: got %0d want 200", lif.y_top_o); end
      lif.hit_enemy_i = 1'b1; lif.tick_i = 1'b1;
      step();
      lif.hit_enemy_i = 1'b0; lif.tick_i = 1'b0;
      checks++; if (lif.kill_o !== 1'b1) begin errors++; $display("FAIL hit_kill: got %b want 1", lif.kill_o); end
      checks++; if (lif.y_top_o !== 10'd200) begin errors++; $display("FAIL hit_freeze: got %0d want 200", lif.y_top_o); end
      checks++; if (lif.state_o !== 3'b100 || lif.active_o !== 1'b0) begin errors++; $display("FAIL hit_state: got state=%b active=%b want 100 0", lif.state_o, lif.active_o); end
      step();
      checks++; if (lif.kill_o !== 1'b0) begin errors++; $display("FAIL kill_width: got %b want 0", lif.kill_o); end
      $display("hit+tick: state=%b y_top=%0d", lif.state_o, lif.y_top_o);
   endtask

   task automatic test_enable_drop();
      lif.enable_i = 1'b0;
      step();
      checks++; if (lif.state_o !== 3'b001) begin errors++; $display("FAIL cool_disable: got %b want 001", lif.state_o); end
      lif.enable_i = 1'b1;
      fire_edge();
      tick_n(2);
      checks++; if (lif.y_top_o !== 10'd432 || lif.active_o !== 1'b1) begin errors++; $display("FAIL drop_pre: got y=%0d active=%b want 432 1", lif.y_top_o, lif.active_o); end
      lif.enable_i = 1'b0;
      step();
      checks++; if (lif.state_o !== 3'b001 || lif.active_o !== 1'b0 || lif.y_top_o !== 10'd432) begin errors++; $display("FAIL drop_idle: got state=%b active=%b y=%0d want 001 0 432", lif.state_o, lif.active_o, lif.y_top_o); end
      lif.enable_i = 1'b1;
      fire_edge();
      checks++; if (lif.active_o !== 1'b1 || lif.shot_laser_o !== 1'b1 || lif.y_top_o !== 10'd440) begin errors++; $display("FAIL drop_refire: got active=%b shot=%b y=%0d want 1 1 440", lif.active_o, lif.shot_laser_o, lif.y_top_o); end
      $display("enable drop: refire state=%b y_top=%0d", lif.state_o, lif.y_top_o);
   endtask

   task automatic test_reset_midflight();
      lif.hit_enemy_i = 1'b1;
      step();
      lif.hit_enemy_i = 1'b0;
      checks++; if (lif.state_o !== 3'b100) begin errors++; $display("FAIL rst_pre: got %b want 100", lif.state_o); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (lif.state_o !== 3'b001 || lif.active_o !== 1'b0 || lif.kill_o !== 1'b0 || lif.shot_laser_o !== 1'b0) begin errors++; $display("FAIL rst_cool: got state=%b active=%b kill=%b shot=%b want 001 0 0 0", lif.state_o, lif.active_o, lif.kill_o, lif.shot_laser_o); end
      checks++; if (lif.x_o !== 10'd0 || lif.y_top_o !== 10'd440) begin errors++; $display("FAIL rst_pos: got x=%0d y=%0d want 0 440", lif.x_o, lif.y_top_o); end
      fire_edge();
      lif.hit_enemy_i = 1'b1; rst = 1'b1;
      step();
      lif.hit_enemy_i = 1'b0; rst = 1'b0;
      checks++; if (lif.kill_o !== 1'b0 || lif.state_o !== 3'b001) begin errors++; $display("FAIL rst_kill_drop: got kill=%b state=%b want 0 001", lif.kill_o, lif.state_o); end
      lif.fire_i = 1'b0;
      step();
      lif.fire_i = 1'b1; rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (lif.shot_laser_o !== 1'b0 || lif.active_o !== 1'b0) begin errors++; $display("FAIL rst_shot_drop: got shot=%b active=%b want 0 0", lif.shot_laser_o, lif.active_o); end
      $display("reset mid-flight: state=%b", lif.state_o);
   endtask

   task automatic test_illegal_state();
      rst = 1'b1;
      force dut.state_q = laser_state_e'(3'b011);
      #2;
      release dut.state_q;
      step();
      rst = 1'b0;
      checks++; if (lif.state_o !== 3'b001 || lif.active_o !== 1'b0) begin errors++; $display("FAIL illegal_recover: got state=%b active=%b want 001 0", lif.state_o, lif.active_o); end
      lif.gun_pos_i = 10'd55;
      fire_edge();
      checks++; if (lif.active_o !== 1'b1 || lif.x_o !== 10'd55) begin errors++; $display("FAIL illegal_refire: got active=%b x=%0d want 1 55", lif.active_o, lif.x_o); end
      $display("illegal state: recovered state=%b x=%0d", lif.state_o, lif.x_o);
   endtask

   initial begin
      test_reset();
      test_fire_latency();
      test_hold_fire();
      test_fly_to_top();
      test_hit_with_tick();
      test_enable_drop();
      test_reset_midflight();
      test_illegal_state();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
